// File: rtl/opgen_pkg.sv
// ----------------------------------------------------------------------------
// opgen_pkg
// Shared definitions for the operand generator:
//   - opgen_state_e     : run-control FSM states (IDLE, RUN, DONE)
//   - OPGEN_DEFAULT_SEED: default LFSR start value
//   - OPGEN_TAP_*       : feedback tap positions of the 16-bit Fibonacci LFSR
//   - opgen_lfsr_next() : one LFSR step
//   - opgen_fix_seed()  : maps the all-zero lock-up seed to 16'h0001
// ----------------------------------------------------------------------------
package opgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } opgen_state_e;

  localparam logic [15:0] OPGEN_DEFAULT_SEED = 16'hACE1;

  // Feedback taps (bit indices into the 16-bit shift register)
  localparam int OPGEN_TAP_0 = 15;
  localparam int OPGEN_TAP_1 = 13;
  localparam int OPGEN_TAP_2 = 12;
  localparam int OPGEN_TAP_3 = 10;

  // One shift-left step; the new LSB is the XOR of the taps
  function automatic logic [15:0] opgen_lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[OPGEN_TAP_0] ^ v[OPGEN_TAP_1] ^ v[OPGEN_TAP_2] ^ v[OPGEN_TAP_3];
    return {v[14:0], fb};
  endfunction

  // An all-zero XOR LFSR never leaves zero, so that seed is substituted
  function automatic logic [15:0] opgen_fix_seed(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h0000) begin
      r = 16'h0001;
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/opgen_lfsr.sv
// ----------------------------------------------------------------------------
// opgen_lfsr
// 16-bit Fibonacci LFSR that advances one step per cycle when step is high.
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   synchronous active-high reset, loads seed (zero -> 1)
//   seed in  16  reset value
//   step in  1   advance the register this cycle
//   q    out 16  current register value
// ----------------------------------------------------------------------------
module opgen_lfsr
  import opgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] lfsr_r;

  // Shift register: reseed on reset, advance only on step
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= opgen_fix_seed(seed);
    end else if (step) begin
      lfsr_r <= opgen_lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/operand_gen.sv
// ----------------------------------------------------------------------------
// operand_gen
// Produces COUNT pseudo-random operand pairs (a, b) for a downstream 2-input
// AND gate under a valid/ready handshake, optionally with the expected result.
//
// Parameters:
//   WIDTH (1..8)   operand width
//   COUNT (1..255) pairs per run
//   SEED           LFSR start value (16'h0000 is replaced by 16'h0001)
//
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   start in  1      begin a run from IDLE or DONE
//   a     out WIDTH  operand A  = lfsr[WIDTH-1:0]
//   b     out WIDTH  operand B  = lfsr[WIDTH+7:8]
//   exp_y out WIDTH  a & b when OPERAND_GEN_EXP_EN is defined, else 0
//   valid out 1      a/b/exp_y hold a pair (state RUN)
//   ready in  1      consumer accepts; transfer = valid && ready
//   busy  out 1      state RUN
//   done  out 1      state DONE
//
// Build option: define OPERAND_GEN_EXP_EN to drive exp_y with a & b.
// ----------------------------------------------------------------------------
module operand_gen
  import opgen_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int          COUNT = 10,
  parameter logic [15:0] SEED  = OPGEN_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_y,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  // Count value held just before the final transfer of a run
  localparam logic [7:0] COUNT_LAST = 8'(COUNT - 1);

  opgen_state_e state_r;
  opgen_state_e state_next_s;
  logic [7:0]   count_r;
  logic [15:0]  lfsr_q_s;
  logic         transfer_s;
  logic         start_run_s;
  logic         last_s;
  logic         unused_lfsr_bits_s;

  // Handshake and run-control decode
  always_comb begin
    transfer_s  = (state_r == RUN) && ready;
    start_run_s = ((state_r == IDLE) || (state_r == DONE)) && start;
    last_s      = transfer_s && (count_r == COUNT_LAST);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; start is not looked at while in RUN
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_r)
      IDLE: begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        done  = 1'b0;
      end
      DONE: begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b1;
      end
      default: begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // Transfer counter: cleared when a run begins, +1 per accepted pair
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (start_run_s) begin
      count_r <= 8'd0;
    end else if (transfer_s) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // The LFSR is not reseeded on a new start, so consecutive runs continue
  // the same sequence; it only advances on accepted pairs, which keeps the
  // operands stable under backpressure.
  opgen_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .step (transfer_s),
    .q    (lfsr_q_s)
  );

  assign a = lfsr_q_s[WIDTH-1:0];
  assign b = lfsr_q_s[WIDTH+7:8];

`ifdef OPERAND_GEN_EXP_EN
  assign exp_y = a & b;
`else
  assign exp_y = {WIDTH{1'b0}};
`endif

  // Not every LFSR bit feeds an operand for small WIDTH
  assign unused_lfsr_bits_s = ^lfsr_q_s;

endmodule

// File: tb/tb_operand_gen.sv
// ----------------------------------------------------------------------------
// tb_operand_gen
// Directed self-checking bench for operand_gen (WIDTH=4, COUNT=10,
// SEED=16'hACE1). Inputs change and outputs are sampled on the falling edge.
// The expected operand sequence comes from a local LFSR step function; the
// first pairs after reset are also checked against hand-computed constants
// (ACE1 -> a=1 b=C, 59C3 -> a=3 b=9).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_operand_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] exp_y;
  logic       valid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  logic [15:0] m;   // model of the LFSR

  operand_gen #(.WIDTH(4), .COUNT(10), .SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .exp_y (exp_y),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [3:0] exp_of(input logic [15:0] v);
`ifdef OPERAND_GEN_EXP_EN
    return v[3:0] & v[11:8];
`else
    return 4'h0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({valid, busy, done} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got v/b/d=%b expected 000", {valid, busy, done});
    end
    tests++; if (a !== 4'h1 || b !== 4'hC) begin
      fails++; $display("FAIL reset_ab: got a=%h b=%h expected a=1 b=c", a, b);
    end
    tests++; if (exp_y !== 4'h0) begin
      fails++; $display("FAIL reset_exp_y: got %h expected 0", exp_y);
    end
    rst = 1'b0; start = 1'b0; ready = 1'b0;
    m = 16'hACE1;
    @(negedge clk);
    tests++; if (valid !== 1'b0 || a !== 4'h1) begin
      fails++; $display("FAIL idle_hold: got valid=%b a=%h expected valid=0 a=1", valid, a);
    end
  endtask

  task automatic test_full_run();
    int nvalid = 0;
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (valid !== 1'b1 || busy !== 1'b1 || a !== 4'h1 || b !== 4'hC) begin
      fails++; $display("FAIL first_pair: got valid=%b busy=%b a=%h b=%h expected 1 1 1 c", valid, busy, a, b);
    end
    for (int i = 0; i < 40 && valid === 1'b1; i++) begin
      if (i == 1) begin
        tests++; if (a !== 4'h3 || b !== 4'h9) begin
          fails++; $display("FAIL second_pair: got a=%h b=%h expected a=3 b=9", a, b);
        end
      end
      tests++; if (a !== m[3:0] || b !== m[11:8] || exp_y !== exp_of(m)) begin
        fails++; $display("FAIL run1_pair%0d: got a=%h b=%h y=%h expected a=%h b=%h y=%h",
                          i, a, b, exp_y, m[3:0], m[11:8], exp_of(m));
      end
      m = step(m);
      nvalid++;
      @(negedge clk);
    end
    tests++; if (nvalid !== 10) begin
      fails++; $display("FAIL run1_len: got %0d valid cycles expected 10", nvalid);
    end
    tests++; if ({valid, busy, done} !== 3'b001) begin
      fails++; $display("FAIL run1_end: got v/b/d=%b expected 001", {valid, busy, done});
    end
  endtask

  task automatic test_ready_when_idle();
    ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (done !== 1'b1 || valid !== 1'b0 || a !== m[3:0] || b !== m[11:8]) begin
      fails++; $display("FAIL ready_in_done: got d=%b v=%b a=%h b=%h expected 1 0 %h %h",
                        done, valid, a, b, m[3:0], m[11:8]);
    end
    ready = 1'b0;
  endtask

  // Restart from DONE with backpressure, a start pulse mid-run and a start
  // coinciding with the final transfer.
  task automatic test_restart_backpressure();
    int xfers = 0;
    int cyc = 0;
    logic [3:0] held_a;
    logic [3:0] held_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (done !== 1'b0 || busy !== 1'b1 || valid !== 1'b1) begin
      fails++; $display("FAIL restart_flags: got v/b/d=%b expected 110", {valid, busy, done});
    end
    tests++; if (a !== m[3:0] || b !== m[11:8]) begin
      fails++; $display("FAIL restart_continue: got a=%h b=%h expected a=%h b=%h", a, b, m[3:0], m[11:8]);
    end
    held_a = a; held_b = b;
    while (valid === 1'b1 && cyc < 100) begin
      tests++; if (a !== m[3:0] || b !== m[11:8] || exp_y !== exp_of(m)) begin
        fails++; $display("FAIL run2_cyc%0d: got a=%h b=%h y=%h expected a=%h b=%h y=%h",
                          cyc, a, b, exp_y, m[3:0], m[11:8], exp_of(m));
      end
      if (cyc >= 3 && cyc <= 7) begin
        tests++; if (a !== held_a || b !== held_b) begin
          fails++; $display("FAIL stall_hold%0d: got a=%h b=%h expected a=%h b=%h", cyc, a, b, held_a, held_b);
        end
      end
      ready = !(cyc >= 2 && cyc <= 6);
      start = (cyc == 9) || (ready && xfers == 9);
      held_a = a; held_b = b;
      if (ready) begin
        m = step(m);
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests++; if (xfers !== 10) begin
      fails++; $display("FAIL run2_len: got %0d transfers expected 10", xfers);
    end
    tests++; if ({valid, busy, done} !== 3'b001) begin
      fails++; $display("FAIL run2_end: got v/b/d=%b expected 001", {valid, busy, done});
    end
    @(negedge clk);
    tests++; if ({valid, busy, done} !== 3'b001) begin
      fails++; $display("FAIL start_on_last: got v/b/d=%b expected 001", {valid, busy, done});
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      m = step(m);
      @(negedge clk);
    end
    tests++; if (valid !== 1'b1 || a !== m[3:0]) begin
      fails++; $display("FAIL pre_reset: got valid=%b a=%h expected 1 %h", valid, a, m[3:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    tests++; if ({valid, busy, done} !== 3'b000 || a !== 4'h1 || b !== 4'hC) begin
      fails++; $display("FAIL mid_reset: got v/b/d=%b a=%h b=%h expected 000 1 c", {valid, busy, done}, a, b);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    tests++; if (valid !== 1'b1 || a !== 4'h1 || b !== 4'hC || exp_y !== 4'h0) begin
      fails++; $display("FAIL reseed_first: got v=%b a=%h b=%h y=%h expected 1 1 c 0", valid, a, b, exp_y);
    end
    @(negedge clk);
    ready = 1'b0;
    tests++; if (a !== 4'h3 || b !== 4'h9 || exp_y !== exp_of(16'h59C3)) begin
      fails++; $display("FAIL reseed_second: got a=%h b=%h y=%h expected 3 9 %h", a, b, exp_y, exp_of(16'h59C3));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; m = 16'hACE1;
    test_reset();
    test_full_run();
    test_ready_when_idle();
    test_restart_backpressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
